reg_bus_arbiter: RTL and testbench
==================================

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, sets the register bus address width.
REQ-002 Parameter DATA_W, default 32, sets the register bus data width.
REQ-003 Parameter CNT_W, default 16, sets the width of the per-requester transaction counters.
REQ-004 aclk  in  1  sole clock; all logic on rising edge.
REQ-005 areset  in  1  synchronous, active-high reset.
REQ-006 m0_req  in  1  requester 0 access request; held high until m0_ack.
REQ-007 m0_wr  in  1  requester 0 access type: 1 = write, 0 = read; stable while m0_req is high.
REQ-008 m0_addr  in  ADDR_W  requester 0 address; stable while m0_req is high.
REQ-009 m0_wdata  in  DATA_W  requester 0 write data; stable while m0_req is high.
REQ-010 m0_ack  out  1  one-cycle completion pulse to requester 0.
REQ-011 m0_rdata  out  DATA_W  requester 0 read or readback data; valid when m0_ack is high.
REQ-012 m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata: same as REQ-006..011 for requester 1.
REQ-013 reg_wen  out  1  write enable to the shared register block.
REQ-014 reg_addr  out  ADDR_W  address to the shared register block.
REQ-015 reg_wdata  out  DATA_W  write data to the shared register block.
REQ-016 reg_rdata  in  DATA_W  combinational read data from the shared register block (function of reg_addr).
REQ-017 busy  out  1  high whenever the state is not IDLE.
REQ-018 m0_count, m1_count  out  CNT_W  completed-transaction counters per requester.

Function
REQ-019 The state machine SHALL have four states: IDLE, ADDR, CAPT and ACK, with all outputs registered or decoded from the state register.
REQ-020 In IDLE, with at least one unmasked request, the block SHALL grant one requester, latch its wr/addr/wdata, and go to ADDR; otherwise it SHALL stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: a single request is granted directly, and when both requests are high the requester not in last_grant wins; last_grant updates on every grant.
REQ-022 In ADDR (exactly 1 cycle), reg_addr and reg_wdata SHALL equal the latched values and reg_wen SHALL equal the latched wr; the next state is CAPT.
REQ-023 In CAPT (exactly 1 cycle), reg_addr SHALL hold the latched address and reg_wen SHALL be 0; the block SHALL register reg_rdata into the granted requester's rdata at the end of the cycle and go to ACK.
REQ-024 For writes, CAPT therefore returns the post-write readback value; for reads, it returns the current register value.
REQ-025 In ACK (exactly 1 cycle), the granted requester's ack SHALL be 1 and its count SHALL increment by 1, wrapping at 2^CNT_W; the next state is IDLE.
REQ-026 Outside ADDR and CAPT, reg_addr, reg_wdata and reg_wen SHALL all be 0.
REQ-027 Fixed latency: request seen in IDLE at cycle N, reg_wen at N+1, capture at N+2, ack at N+3; minimum spacing between grants is 4 cycles.
REQ-028 A requester SHALL drop req in the cycle after its ack; the arbiter SHALL mask a requester during its own ack cycle, so no back-to-back regrant occurs.
REQ-029 The non-granted requester's ack, rdata and count SHALL remain unchanged during the transaction.
REQ-030 Behaviour when req drops before ack, or when fields change mid-request, is a protocol violation; the latched values SHALL still be used.

Reset
REQ-031 While areset is high at a clock edge, the block SHALL set state = IDLE, last_grant = 1 (m0 wins the first tie), m0_ack = m1_ack = 0, m0_rdata = m1_rdata = 0, counts = 0, reg_wen = 0, reg_addr = 0, reg_wdata = 0, busy = 0.
REQ-032 Reset in any state SHALL abort the transaction with no ack; a write issued in ADDR before the reset edge is not undone.

Verification
REQ-033 Reset, then idle 10 cycles -> all outputs 0, busy = 0; a read of 0x4 by m1 returns m1_rdata = 0x00001111 at N+3 and m1_count = 1.
REQ-034 m0 writes 0xDEADBEEF to 0x8 -> reg_wen = 1 only at N+1 with reg_addr = 0x8; m0_ack at N+3 with m0_rdata = 0xDEADBEEF.
REQ-035 m0_req and m1_req both high after reset -> m0 is served first and m1 second; both raised again -> m0 first again, with last_grant alternating 0,1,0,1.
REQ-036 m1 reads unmapped 0x20 -> m1_rdata = 0, ack at N+3, m1_count increments.
REQ-037 areset asserted during CAPT of a m0 read -> no m0_ack, state returns to IDLE, and a re-request completes normally.
REQ-038 Preset m0_count to 0xFFFF via 65535 transactions, then one more -> m0_count = 0x0000.

Source files
------------

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin arbiter granting two requesters fixed-latency
// access (ADDR -> CAPT -> ACK) to a shared single-port register block.
`default_nettype none

module reg_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              reg_wen,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  m0_count,
  output logic [CNT_W-1:0]  m1_count
);

  typedef enum logic [1:0] {IDLE, ADDR, CAPT, ACK} state_t;

  state_t state;
  logic   last_grant;
  logic   gnt;

  logic              elig0, elig1, pick;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A requester is never eligible while its own ack is being presented.
  assign elig0 = m0_req & ~m0_ack;
  assign elig1 = m1_req & ~m1_ack;

  // pick = 1 selects m1; on a tie the requester not granted last time wins.
  assign pick      = (elig0 & elig1) ? ~last_grant : elig1;
  assign sel_wr    = pick ? m1_wr    : m0_wr;
  assign sel_addr  = pick ? m1_addr  : m0_addr;
  assign sel_wdata = pick ? m1_wdata : m0_wdata;

  assign busy = (state != IDLE);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_count   <= '0;
      m1_count   <= '0;
      reg_wen    <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (elig0 | elig1) begin
            gnt        <= pick;
            last_grant <= pick;
            // The register-bus outputs double as the latched request fields.
            reg_wen    <= sel_wr;
            reg_addr   <= sel_addr;
            reg_wdata  <= sel_wdata;
            state      <= ADDR;
          end
        end
        ADDR: begin
          reg_wen <= 1'b0;
          state   <= CAPT;
        end
        CAPT: begin
          if (gnt) begin
            m1_rdata <= reg_rdata;
            m1_ack   <= 1'b1;
            m1_count <= m1_count + CNT_W'(1);
          end else begin
            m0_rdata <= reg_rdata;
            m0_ack   <= 1'b1;
            m0_count <= m0_count + CNT_W'(1);
          end
          reg_addr  <= '0;
          reg_wdata <= '0;
          state     <= ACK;
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_bus_arbiter.sv
// Randomized self-checking bench for reg_bus_arbiter with an 8-word register
// block (0x00..0x1C) and a transaction-level reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_reg_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 8;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          mem_init = 1'b1;
  logic          f_req   [2];
  logic          f_wr    [2];
  logic [AW-1:0] f_addr  [2];
  logic [DW-1:0] f_wdata [2];
  logic          m0_ack, m1_ack, reg_wen, busy;
  logic [DW-1:0] m0_rdata, m1_rdata, reg_wdata, reg_rdata;
  logic [AW-1:0] reg_addr;
  logic [CW-1:0] m0_count, m1_count;

  always #5 aclk = ~aclk;

  reg_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .aclk(aclk), .areset(areset),
    .m0_req(f_req[0]), .m0_wr(f_wr[0]), .m0_addr(f_addr[0]), .m0_wdata(f_wdata[0]),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(f_req[1]), .m1_wr(f_wr[1]), .m1_addr(f_addr[1]), .m1_wdata(f_wdata[1]),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .reg_wen(reg_wen), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .busy(busy), .m0_count(m0_count), .m1_count(m1_count)
  );

  // Register block: word i resets to i*0x1111, addresses >= 0x20 are unmapped.
  logic [DW-1:0] regs [8];
  assign reg_rdata = (reg_addr < 32) ? regs[reg_addr[4:2]] : '0;
  always @(posedge aclk) begin
    if (mem_init) begin
      for (int i = 0; i < 8; i++) regs[i] <= DW'(i * 32'h1111);
    end else if (reg_wen && reg_addr < 32) begin
      regs[reg_addr[4:2]] <= reg_wdata;
    end
  end

  logic [DW-1:0] mdl_mem   [8];
  logic [DW-1:0] exp_rdata [2];
  logic [CW-1:0] exp_cnt   [2];
  int            last;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_fields(input int id, input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata);
    f_wr[id]    = wr;
    f_addr[id]  = addr;
    f_wdata[id] = wdata;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_rdata[i] = '0;
      exp_cnt[i]   = '0;
    end
    last = 1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_acks"}, {m0_ack, m1_ack}, 0);
    check({tag, "_wen"}, reg_wen, 0);
    check({tag, "_addr"}, reg_addr, 0);
    check({tag, "_wdata"}, reg_wdata, 0);
    check({tag, "_rdata"}, {m0_rdata, m1_rdata}, {exp_rdata[0], exp_rdata[1]});
    check({tag, "_counts"}, {m0_count, m1_count}, {exp_cnt[0], exp_cnt[1]});
  endtask

  task automatic do_reset();
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    model_reset();
    check_quiet("reset");
  endtask

  // Called in an IDLE cycle with f_req[id] high; the model expects requester
  // id to be granted at the coming edge and acked three cycles later.
  task automatic serve(input int id);
    int   oth;
    logic mapped;
    oth    = 1 - id;
    mapped = (f_addr[id] < 32);
    @(posedge aclk); #1;
    check("busy_addr", busy, 1);
    check("wen_addr", reg_wen, f_wr[id]);
    check("addr_addr", reg_addr, f_addr[id]);
    check("wdata_addr", reg_wdata, f_wdata[id]);
    @(posedge aclk); #1;
    check("wen_capt", reg_wen, 0);
    check("addr_capt", reg_addr, f_addr[id]);
    check("ack_capt", {m0_ack, m1_ack}, 0);
    if (f_wr[id] && mapped) mdl_mem[f_addr[id][4:2]] = f_wdata[id];
    exp_rdata[id] = mapped ? mdl_mem[f_addr[id][4:2]] : '0;
    exp_cnt[id]   = exp_cnt[id] + 1'b1;
    @(posedge aclk); #1;
    check("ack", (id == 1) ? m1_ack : m0_ack, 1);
    check("ack_other", (id == 1) ? m0_ack : m1_ack, 0);
    check("rdata", (id == 1) ? m1_rdata : m0_rdata, exp_rdata[id]);
    check("count", (id == 1) ? m1_count : m0_count, exp_cnt[id]);
    check("rdata_other", (id == 1) ? m0_rdata : m1_rdata, exp_rdata[oth]);
    check("count_other", (id == 1) ? m0_count : m1_count, exp_cnt[oth]);
    check("bus_ack", {reg_wen, reg_addr}, 0);
    f_req[id] = 1'b0;
    last      = id;
    @(posedge aclk); #1;
    check("busy_idle", busy, 0);
    check("ack_idle", {m0_ack, m1_ack}, 0);
  endtask

  task automatic round(input logic r0, input logic r1);
    int first;
    for (int i = 0; i < 2; i++)
      set_fields(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 11) * 4), DW'($urandom));
    f_req[0] = r0;
    f_req[1] = r1;
    if (r0 && r1) begin
      first = (last == 1) ? 0 : 1;
      serve(first);
      serve(1 - first);
    end else if (r0) begin
      serve(0);
    end else if (r1) begin
      serve(1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      f_req[i] = 1'b0;
      set_fields(i, 1'b0, '0, '0);
    end
    for (int i = 0; i < 8; i++) mdl_mem[i] = DW'(i * 32'h1111);
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    areset   = 1'b0;
    mem_init = 1'b0;
    repeat (10) @(posedge aclk);
    #1;
    check_quiet("idle10");

    set_fields(1, 1'b0, 32'h4, 32'h0);
    f_req[1] = 1'b1;
    serve(1);
    check("m1_rd4", m1_rdata, 32'h0000_1111);
    check("m1_cnt1", m1_count, 1);

    set_fields(0, 1'b1, 32'h8, 32'hDEAD_BEEF);
    f_req[0] = 1'b1;
    serve(0);
    check("m0_wr8", m0_rdata, 32'hDEAD_BEEF);

    do_reset();
    round(1'b1, 1'b1);
    round(1'b1, 1'b1);
    check("tie_last", last, 1);

    set_fields(1, 1'b0, 32'h20, 32'h0);
    f_req[1] = 1'b1;
    serve(1);
    check("m1_unmapped", m1_rdata, 0);

    // Abort a m0 read during CAPT, then reissue it.
    set_fields(0, 1'b0, 32'h4, 32'h0);
    f_req[0] = 1'b1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    check("abort_in_capt", busy, 1);
    do_reset();
    serve(0);

    for (int k = 0; k < 60; k++) begin
      int r;
      r = $urandom_range(1, 3);
      round(1'(r), 1'(r >> 1));
    end

    do_reset();
    for (int k = 0; k < (1 << CW) - 1; k++) begin
      set_fields(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 11) * 4), DW'($urandom));
      f_req[0] = 1'b1;
      serve(0);
    end
    check("cnt_max", m0_count, {CW{1'b1}});
    set_fields(0, 1'b0, 32'h0, 32'h0);
    f_req[0] = 1'b1;
    serve(0);
    check("cnt_wrap", m0_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
